// File: rtl/stall_ctrl_pkg.sv
// stall_ctrl_pkg: shared encodings for the hazard/stall controller.
package stall_ctrl_pkg;
    localparam logic [1:0] MD_NONE    = 2'b00;
    localparam logic [1:0] MD_MULT    = 2'b01;
    localparam logic [1:0] MD_DIV     = 2'b10;
    localparam logic [1:0] TUSE_NEVER = 2'd3;
    localparam logic [1:0] TNEW_LW    = 2'd2;
    localparam logic [1:0] TNEW_ALU   = 2'd1;
    localparam logic [1:0] TNEW_NOW   = 2'd0;

    // A source register hazards against one in-flight writer if the result arrives too late.
    function automatic logic raw_hazard(input logic [4:0] src, input logic [1:0] tuse,
                                        input logic [4:0] a3, input logic [1:0] tnew);
        return (src != 5'd0) && (src == a3) && (tuse < tnew);
    endfunction
endpackage

// File: rtl/stall_ctrl_md_busy_cnt.sv
// md_busy_cnt: mult/div busy counter, loaded as an MD instruction leaves E.
module md_busy_cnt
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] i_md_kind,
    output logic       o_busy
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge Clk) begin
        if (Reset)
            r_cnt <= '0;
        else if (i_md_kind == MD_MULT)
            r_cnt <= CNT_W'(MULT_CYCLES);
        else if (i_md_kind == MD_DIV)
            r_cnt <= CNT_W'(DIV_CYCLES);
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_busy = (r_cnt != '0) || (i_md_kind != MD_NONE);
endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl: D-stage hazard detection against shadow E/M state, driving PC/F->D stalls and the D->E bubble.
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [4:0] D_Rs,
    input  logic [4:0] D_Rt,
    input  logic [1:0] D_TuseRs,
    input  logic [1:0] D_TuseRt,
    input  logic [4:0] D_A3,
    input  logic [1:0] D_Tnew,
    input  logic [1:0] D_MDKind,
    input  logic       D_UsesMD,
    output logic       F_PC_En,
    output logic       D_RegD_En,
    output logic       E_RegE_Clr,
    output logic       Busy
);
    logic [4:0] r_e_a3;
    logic [1:0] r_e_tnew;
    logic [1:0] r_e_md;
    logic [4:0] r_m_a3;
    logic [1:0] r_m_tnew;
    logic       w_stall_rs;
    logic       w_stall_rt;
    logic       w_stall;

    assign w_stall_rs = raw_hazard(D_Rs, D_TuseRs, r_e_a3, r_e_tnew) ||
                        raw_hazard(D_Rs, D_TuseRs, r_m_a3, r_m_tnew);
    assign w_stall_rt = raw_hazard(D_Rt, D_TuseRt, r_e_a3, r_e_tnew) ||
                        raw_hazard(D_Rt, D_TuseRt, r_m_a3, r_m_tnew);
    assign w_stall    = w_stall_rs || w_stall_rt || (D_UsesMD && Busy);

    assign F_PC_En    = ~w_stall;
    assign D_RegD_En  = ~w_stall;
    assign E_RegE_Clr = w_stall;

    // M advances even while D stalls, so the E bubble drains the older writer out.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_e_a3   <= '0;
            r_e_tnew <= '0;
            r_e_md   <= MD_NONE;
            r_m_a3   <= '0;
            r_m_tnew <= '0;
        end else begin
            r_e_a3   <= w_stall ? 5'd0 : D_A3;
            r_e_tnew <= w_stall ? 2'd0 : D_Tnew;
            r_e_md   <= w_stall ? MD_NONE : D_MDKind;
            r_m_a3   <= r_e_a3;
            r_m_tnew <= (r_e_tnew == 2'd0) ? 2'd0 : r_e_tnew - 2'd1;
        end
    end

    md_busy_cnt #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md_busy_cnt (
        .Clk      (Clk),
        .Reset    (Reset),
        .i_md_kind(r_e_md),
        .o_busy   (Busy)
    );
endmodule

// File: tb/tb_stall_ctrl.sv
// tb_stall_ctrl: directed checks of hazard stalls, MDU busy stalls and reset behaviour.
module tb_stall_ctrl;
    logic       Clk = 1'b0;
    logic       Reset;
    logic [4:0] D_Rs, D_Rt, D_A3;
    logic [1:0] D_TuseRs, D_TuseRt, D_Tnew, D_MDKind;
    logic       D_UsesMD;
    logic       F_PC_En, D_RegD_En, E_RegE_Clr, Busy;
    int         checks = 0;
    int         errors = 0;

    stall_ctrl dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .D_Rs      (D_Rs),
        .D_Rt      (D_Rt),
        .D_TuseRs  (D_TuseRs),
        .D_TuseRt  (D_TuseRt),
        .D_A3      (D_A3),
        .D_Tnew    (D_Tnew),
        .D_MDKind  (D_MDKind),
        .D_UsesMD  (D_UsesMD),
        .F_PC_En   (F_PC_En),
        .D_RegD_En (D_RegD_En),
        .E_RegE_Clr(E_RegE_Clr),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        #1;
        chk(tag, {5'd0, F_PC_En, D_RegD_En, E_RegE_Clr}, {5'd0, ~exp, ~exp, exp});
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [1:0] trs, input logic [4:0] rt,
                         input logic [1:0] trt, input logic [4:0] a3, input logic [1:0] tnew,
                         input logic [1:0] md, input logic umd);
        D_Rs = rs; D_TuseRs = trs; D_Rt = rt; D_TuseRt = trt;
        D_A3 = a3; D_Tnew = tnew; D_MDKind = md; D_UsesMD = umd;
    endtask

    task automatic idle();
        set_d(0, 3, 0, 3, 0, 0, 0, 0);
    endtask

    initial begin
        Reset = 1'b1;
        idle();
        tick();
        tick();
        Reset = 1'b0;
        chk_stall("reset_stall", 1'b0);
        chk("reset_busy", {7'd0, Busy}, 8'd0);

        // lw $t0 then dependent addu (Tuse 0): E hazard, then M hazard, then clear
        set_d(0, 3, 0, 3, 8, 2, 0, 0);
        chk_stall("lw_issue", 1'b0);
        tick();
        set_d(8, 0, 0, 3, 9, 1, 0, 0);
        chk_stall("lw_use_e", 1'b1);
        tick();
        chk_stall("lw_use_m", 1'b1);
        chk("m_tnew_after_lw", {6'd0, dut.r_m_tnew}, 8'd1);
        tick();
        chk_stall("lw_use_clear", 1'b0);
        tick();
        idle();
        tick();
        tick();

        // lw then sw reading rt: TuseRt=2 is fine, TuseRt=1 stalls
        set_d(0, 3, 0, 3, 8, 2, 0, 0);
        tick();
        set_d(5, 1, 8, 2, 0, 0, 0, 0);
        chk_stall("sw_rt_tuse2", 1'b0);
        D_TuseRt = 2'd1;
        chk_stall("sw_rt_tuse1", 1'b1);
        idle();
        tick();
        tick();

        // writes to $0 never create hazards
        set_d(0, 3, 0, 3, 0, 1, 0, 0);
        tick();
        set_d(0, 0, 0, 0, 9, 1, 0, 0);
        chk_stall("reg0_no_stall", 1'b0);
        idle();
        tick();
        tick();

        // E=$9 Tnew1, M=$8 Tnew1: either match stalls, Tuse=3 never stalls
        set_d(0, 3, 0, 3, 8, 2, 0, 0);
        tick();
        set_d(0, 3, 0, 3, 9, 1, 0, 0);
        tick();
        set_d(0, 3, 8, 0, 0, 0, 0, 0);
        chk_stall("m_match_rt", 1'b1);
        set_d(9, 0, 0, 3, 0, 0, 0, 0);
        chk_stall("e_match_rs", 1'b1);
        set_d(9, 3, 8, 3, 0, 0, 0, 0);
        chk_stall("tuse_never", 1'b0);
        idle();
        tick();
        tick();

        // mult then mfhi: 6 stall cycles, then issue
        set_d(0, 3, 0, 3, 0, 0, 1, 1);
        chk_stall("mult_issue", 1'b0);
        tick();
        set_d(0, 3, 0, 3, 8, 1, 0, 1);
        for (int i = 0; i < 6; i++) begin
            chk_stall($sformatf("mfhi_wait%0d", i), 1'b1);
            tick();
        end
        chk_stall("mfhi_issue", 1'b0);
        chk("mfhi_busy", {7'd0, Busy}, 8'd0);
        idle();
        tick();
        tick();

        // back-to-back mult with a lw between; E holds zeros and M drains while stalled
        set_d(0, 3, 0, 3, 0, 0, 1, 1);
        tick();
        set_d(0, 3, 0, 3, 8, 2, 0, 0);
        chk_stall("lw_during_busy", 1'b0);
        tick();
        set_d(0, 3, 0, 3, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            chk_stall($sformatf("mult2_stall%0d", i), 1'b1);
            tick();
            chk($sformatf("e_shadow%0d", i), {dut.r_e_a3, dut.r_e_md, 1'b0} | {6'd0, dut.r_e_tnew}, 8'd0);
            chk($sformatf("m_shadow%0d", i), {1'b0, dut.r_m_a3, dut.r_m_tnew},
                (i == 0) ? {1'b0, 5'd8, 2'd1} : 8'd0);
        end
        chk_stall("mult2_stall3", 1'b1);
        tick();
        chk_stall("mult2_stall4", 1'b1);
        tick();
        chk_stall("mult2_issue", 1'b0);
        tick();
        idle();
        chk("mult2_in_e_busy", {7'd0, Busy}, 8'd1);
        repeat (6) tick();
        chk("mult2_drained", {7'd0, Busy}, 8'd0);

        // div loads 10; reset at Cnt=7 clears busy on the next cycle
        set_d(0, 3, 0, 3, 0, 0, 2, 1);
        tick();
        idle();
        repeat (4) tick();
        chk("div_cnt7", {4'd0, dut.u_md_busy_cnt.r_cnt}, 8'd7);
        D_UsesMD = 1'b1;
        chk_stall("div_busy_stall", 1'b1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("reset_mid_busy", {7'd0, Busy}, 8'd0);
        chk_stall("reset_mid_busy_stall", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
